// File: rtl/i2c_req_arbiter.sv
// i2c_req_arbiter: shares one i2c_controller write port between two requesters.
// Latency: req sampled at edge N -> ack + latched bytes after N, i2c_start from N+1.
// Backpressure: requests wait until ack; no grant while synced ready is low; start held until accept/timeout.
//
// Ports: clk_in/reset (async, active-high); req[1:0] level requests with packed
//   req_dev/req_reg/req_data bytes ([7:0] = req0, [15:8] = req1); ack/done one-cycle
//   per-requester pulses, err valid with done (1 = timeout), busy from latch through done;
//   i2c_start/i2c_dev/i2c_reg/i2c_data to the controller, i2c_ready from its ready_out.
// Option: define I2C_ARB_FIXED_PRIO_EN for fixed priority (requester 0 always wins ties);
//   default is round-robin.
module i2c_req_arbiter #(
    parameter int TIMEOUT_CYCLES = 2048,
    parameter int CNT_W          = 12
) (
    input  logic        clk_in,
    input  logic        reset,
    input  logic [1:0]  req,
    input  logic [15:0] req_dev,
    input  logic [15:0] req_reg,
    input  logic [15:0] req_data,
    output logic [1:0]  ack,
    output logic [1:0]  done,
    output logic        err,
    output logic        busy,
    output logic        i2c_start,
    output logic [7:0]  i2c_dev,
    output logic [7:0]  i2c_reg,
    output logic [7:0]  i2c_data,
    input  logic        i2c_ready
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state_q;
    logic             rdy_meta_q;
    logic             rdy_s_q;
    logic [1:0]       ack_q;
    logic [1:0]       done_q;
    logic             err_q;
    logic             busy_q;
    logic             start_q;
    logic [7:0]       dev_q;
    logic [7:0]       reg_q;
    logic [7:0]       data_q;
    logic             win_q;
    logic             win_d;
    logic             to_q;
    logic [CNT_W-1:0] cnt_q;
`ifndef I2C_ARB_FIXED_PRIO_EN
    logic             last_q;
`endif

    // ready_out comes from the divided-clock domain.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            rdy_meta_q <= 1'b0;
            rdy_s_q    <= 1'b0;
        end else begin
            rdy_meta_q <= i2c_ready;
            rdy_s_q    <= rdy_meta_q;
        end
    end

    // Winner select: a lone request always wins; a tie goes to the
    // requester not served last (or to requester 0 in fixed-priority mode).
    always_comb begin
        win_d = 1'b0;
        if (req == 2'b10) begin
            win_d = 1'b1;
        end else if (req == 2'b11) begin
`ifdef I2C_ARB_FIXED_PRIO_EN
            win_d = 1'b0;
`else
            win_d = ~last_q;
`endif
        end
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ack_q   <= 2'b00;
            done_q  <= 2'b00;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            start_q <= 1'b0;
            dev_q   <= 8'h00;
            reg_q   <= 8'h00;
            data_q  <= 8'h00;
            win_q   <= 1'b0;
            to_q    <= 1'b0;
            cnt_q   <= '0;
`ifndef I2C_ARB_FIXED_PRIO_EN
            last_q  <= 1'b1;
`endif
        end else begin
            ack_q  <= 2'b00;
            done_q <= 2'b00;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    busy_q <= 1'b0;
                    if ((req != 2'b00) && rdy_s_q) begin
                        win_q   <= win_d;
                        ack_q   <= win_d ? 2'b10 : 2'b01;
                        dev_q   <= win_d ? req_dev[15:8]  : req_dev[7:0];
                        reg_q   <= win_d ? req_reg[15:8]  : req_reg[7:0];
                        data_q  <= win_d ? req_data[15:8] : req_data[7:0];
                        busy_q  <= 1'b1;
                        state_q <= START;
                    end
                end
                START: begin
                    // Ready falling only counts as acceptance once start is
                    // actually on the wire; the counter only runs while it is.
                    if (start_q && !rdy_s_q) begin
                        start_q <= 1'b0;
                        to_q    <= 1'b0;
                        state_q <= BUSY;
                    end else if (start_q && (cnt_q == CNT_LAST)) begin
                        start_q <= 1'b0;
                        to_q    <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        start_q <= 1'b1;
                        if (start_q) begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                BUSY: begin
                    if (rdy_s_q) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= win_q ? 2'b10 : 2'b01;
                    err_q   <= to_q;
                    cnt_q   <= '0;
`ifndef I2C_ARB_FIXED_PRIO_EN
                    last_q  <= win_q;
`endif
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ack       = ack_q;
    assign done      = done_q;
    assign err       = err_q;
    assign busy      = busy_q;
    assign i2c_start = start_q;
    assign i2c_dev   = dev_q;
    assign i2c_reg   = reg_q;
    assign i2c_data  = data_q;

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// tb_i2c_req_arbiter: directed bench for i2c_req_arbiter with a simple controller model.
// Latency: n/a (bench).
// Backpressure: controller model drops ready a few cycles after start, raises it after a hold time.
module tb_i2c_req_arbiter;

    localparam int T = 2048;

    logic        clk_in = 1'b0;
    logic        reset  = 1'b1;
    logic [1:0]  req    = 2'b00;
    logic [15:0] req_dev  = 16'h0000;
    logic [15:0] req_reg  = 16'h0000;
    logic [15:0] req_data = 16'h0000;
    logic [1:0]  ack;
    logic [1:0]  done;
    logic        err;
    logic        busy;
    logic        i2c_start;
    logic [7:0]  i2c_dev;
    logic [7:0]  i2c_reg;
    logic [7:0]  i2c_data;
    logic        i2c_ready;

    // Controller model state.
    logic mdl_rdy   = 1'b1;
    logic mdl_en    = 1'b1;
    int   mdl_busy  = 200;
    logic hold_low  = 1'b0;

    int tests_run    = 0;
    int tests_failed = 0;

    assign i2c_ready = mdl_rdy && !hold_low;

    always #5 clk_in = ~clk_in;

    i2c_req_arbiter #(.TIMEOUT_CYCLES(T), .CNT_W(12)) dut (
        .clk_in    (clk_in),
        .reset     (reset),
        .req       (req),
        .req_dev   (req_dev),
        .req_reg   (req_reg),
        .req_data  (req_data),
        .ack       (ack),
        .done      (done),
        .err       (err),
        .busy      (busy),
        .i2c_start (i2c_start),
        .i2c_dev   (i2c_dev),
        .i2c_reg   (i2c_reg),
        .i2c_data  (i2c_data),
        .i2c_ready (i2c_ready)
    );

    // Controller: accept start by dropping ready 4 cycles later, hold busy for mdl_busy cycles.
    initial begin
        forever begin
            @(posedge clk_in);
            #1;
            if (mdl_en && i2c_start && mdl_rdy) begin
                repeat (4) @(posedge clk_in);
                #1 mdl_rdy = 1'b0;
                repeat (mdl_busy) @(posedge clk_in);
                #1 mdl_rdy = 1'b1;
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_ack(input int budget, output logic [1:0] a, output int n);
        a = 2'b00;
        n = 0;
        while (a == 2'b00 && n < budget) begin
            @(negedge clk_in);
            n++;
            a = ack;
        end
    endtask

    task automatic wait_done(input int budget, output logic [1:0] d, output logic e, output int n);
        d = 2'b00;
        e = 1'b0;
        n = 0;
        while (d == 2'b00 && n < budget) begin
            @(negedge clk_in);
            n++;
            d = done;
            e = err;
        end
    endtask

    task automatic do_reset();
        @(negedge clk_in);
        reset = 1'b1;
        @(negedge clk_in);
        reset = 1'b0;
        repeat (3) @(negedge clk_in);
    endtask

    logic [1:0] a;
    logic [1:0] d;
    logic       e;
    int         n;
    int         pulses;

    initial begin
        // ---- reset state ----
        @(negedge clk_in);
        check_val("rst_ack",   32'(ack), 32'h0);
        check_val("rst_done",  32'(done), 32'h0);
        check_val("rst_err",   32'(err), 32'h0);
        check_val("rst_busy",  32'(busy), 32'h0);
        check_val("rst_start", 32'(i2c_start), 32'h0);
        check_val("rst_bytes", {8'h0, i2c_dev, i2c_reg, i2c_data}, 32'h0);
        @(negedge clk_in);
        reset = 1'b0;
        repeat (3) @(negedge clk_in);

        // ---- single req0 ----
        mdl_busy = 200;
        req_dev = 16'h003C; req_reg = 16'h0020; req_data = 16'h005A;
        req = 2'b01;
        wait_ack(10, a, n);
        check_val("s_ack", 32'(a), 32'h1);
        check_val("s_ack_lat", n, 1);
        check_val("s_bytes", {8'h0, i2c_dev, i2c_reg, i2c_data}, 32'h003C205A);
        check_val("s_busy", 32'(busy), 32'h1);
        req = 2'b00;
        req_dev = 16'hFFFF; req_reg = 16'hFFFF; req_data = 16'hFFFF;
        @(negedge clk_in);
        check_val("s_ack_one", 32'(ack), 32'h0);
        check_val("s_start", 32'(i2c_start), 32'h1);
        check_val("s_stable", {8'h0, i2c_dev, i2c_reg, i2c_data}, 32'h003C205A);
        wait_done(400, d, e, n);
        check_val("s_done", 32'(d), 32'h1);
        check_val("s_err", 32'(e), 32'h0);
        check_val("s_busy_done", 32'(busy), 32'h1);
        @(negedge clk_in);
        check_val("s_done_one", 32'(done), 32'h0);
        check_val("s_busy_end", 32'(busy), 32'h0);
        repeat (5) @(negedge clk_in);

        // ---- ties: round-robin (or fixed priority) with req held at 11 ----
        do_reset();
        mdl_busy = 20;
        req_dev = 16'hB1A0; req_reg = 16'hB2A2; req_data = 16'hB3A3;
        req = 2'b11;
`ifdef I2C_ARB_FIXED_PRIO_EN
        for (int k = 0; k < 3; k++) begin
            wait_ack(60, a, n);
            check_val("fp_ack", 32'(a), 32'h1);
            check_val("fp_dev", 32'(i2c_dev), 32'hA0);
            wait_done(100, d, e, n);
            check_val("fp_done", 32'(d), 32'h1);
        end
`else
        wait_ack(10, a, n);
        check_val("rr_ack0", 32'(a), 32'h1);
        check_val("rr_dev0", 32'(i2c_dev), 32'hA0);
        wait_done(100, d, e, n);
        check_val("rr_done0", 32'(d), 32'h1);
        @(negedge clk_in);
        check_val("rr_ack1_gap", 32'(ack), 32'h2);
        check_val("rr_dev1", 32'(i2c_dev), 32'hB1);
        wait_done(100, d, e, n);
        check_val("rr_done1", 32'(d), 32'h2);
        @(negedge clk_in);
        check_val("rr_ack2_gap", 32'(ack), 32'h1);
        wait_done(100, d, e, n);
        check_val("rr_done2", 32'(d), 32'h1);
`endif
        req = 2'b00;
        repeat (30) @(negedge clk_in);

        // ---- timeout: controller never accepts ----
        mdl_en = 1'b0;
        req_dev = 16'h0011; req_reg = 16'h0022; req_data = 16'h0033;
        req = 2'b01;
        wait_ack(10, a, n);
        check_val("to_ack", 32'(a), 32'h1);
        req = 2'b00;
        @(negedge clk_in);
        check_val("to_start", 32'(i2c_start), 32'h1);
        wait_done(T + 20, d, e, n);
        check_val("to_done", 32'(d), 32'h1);
        check_val("to_err", 32'(e), 32'h1);
        check_val("to_cycles", n, T + 1);
        check_val("to_start_off", 32'(i2c_start), 32'h0);
        mdl_en = 1'b1;
        @(negedge clk_in);
        req_dev = 16'h4400; req = 2'b10;
        wait_ack(10, a, n);
        check_val("to_next_ack", 32'(a), 32'h2);
        check_val("to_next_dev", 32'(i2c_dev), 32'h44);
        req = 2'b00;
        wait_done(100, d, e, n);
        check_val("to_next_done", 32'(d), 32'h2);
        check_val("to_next_err", 32'(e), 32'h0);
        repeat (5) @(negedge clk_in);

        // ---- reset in the middle of BUSY ----
        req = 2'b01;
        wait_ack(10, a, n);
        check_val("rb_ack", 32'(a), 32'h1);
        req = 2'b00;
        repeat (12) @(negedge clk_in);
        check_val("rb_pre_start", 32'(i2c_start), 32'h0);
        check_val("rb_pre_busy", 32'(busy), 32'h1);
        reset = 1'b1;
        #1;
        check_val("rb_start", 32'(i2c_start), 32'h0);
        check_val("rb_busy", 32'(busy), 32'h0);
        check_val("rb_done", 32'(done), 32'h0);
        @(negedge clk_in);
        reset = 1'b0;
        pulses = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk_in);
            if (done != 2'b00 || ack != 2'b00) pulses++;
        end
        check_val("rb_no_pulse", pulses, 0);

        // ---- ready low in IDLE holds off the grant ----
        hold_low = 1'b1;
        repeat (5) @(negedge clk_in);
        req_dev = 16'h7700; req = 2'b10;
        pulses = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk_in);
            if (ack != 2'b00) pulses++;
        end
        check_val("rl_no_ack", pulses, 0);
        hold_low = 1'b0;
        wait_ack(10, a, n);
        check_val("rl_ack", 32'(a), 32'h2);
        check_val("rl_ack_lat", n, 3);
        req = 2'b00;
        wait_done(100, d, e, n);
        check_val("rl_done", 32'(d), 32'h2);

        repeat (5) @(negedge clk_in);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
